// File: rtl/memory_game_seq.sv
// memory_game_seq: Simon-style multi-round pattern recall game driven by an LFSR.
// Optional ENTRY_TIMEOUT_EN adds a WAIT-state entry timeout.
module memory_game_seq #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter logic [WIDTH-1:0] TAPS = 8'h81,
  parameter int DISP_CYCLES = 4,
  parameter bit REVERSE = 1'b1,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic [WIDTH-1:0] load,
  input  logic [WIDTH-1:0] x,
  input  logic submit,
  output logic [WIDTH-1:0] display,
  output logic disp_valid,
  output logic [1:0] result,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic busy
);
  localparam int LW = $clog2(DEPTH+1);
  localparam int CW = $clog2(DISP_CYCLES+1);
  localparam logic [2:0] IDLE = 3'd0, GEN = 3'd1, SHOW = 3'd2, WAIT = 3'd3, WIN = 3'd4, LOSE = 3'd5;
  logic [2:0] state;
  logic [WIDTH-1:0] q, exp_val;
  logic [WIDTH-1:0] mem [1<<LW];
  logic [LW-1:0] idx;
  logic [CW-1:0] cnt;
  logic submit_d, accept, last, blank;
`ifdef ENTRY_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES+1);
  logic [TW-1:0] tcnt;
`endif
  assign accept = submit & ~submit_d;
  assign last = idx == level - LW'(1);
  assign blank = cnt == CW'(DISP_CYCLES);
  always_comb begin
    exp_val = '0;
    for (int i = 0; i < WIDTH; i++) exp_val[i] = REVERSE ? mem[idx][WIDTH-1-i] : mem[idx][i];
  end
  // Pattern buffer carries no reset: entries are always written before being read.
  always_ff @(posedge clk) if (state == GEN) mem[level] <= q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      q <= '0;
      idx <= '0;
      cnt <= '0;
      submit_d <= 1'b0;
      display <= '0;
      disp_valid <= 1'b0;
      result <= 2'd0;
      level <= '0;
      busy <= 1'b0;
`ifdef ENTRY_TIMEOUT_EN
      tcnt <= '0;
`endif
    end else begin
      submit_d <= submit;
      case (state)
        IDLE, WIN, LOSE: if (start) begin
          q <= load == '0 ? WIDTH'(1) : load;
          level <= '0;
          result <= 2'd0;
          busy <= 1'b1;
          state <= GEN;
        end
        GEN: begin
          q <= {^(q & TAPS), q[WIDTH-1:1]};
          level <= level + LW'(1);
          idx <= '0;
          cnt <= '0;
          result <= 2'd0;
          state <= SHOW;
        end
        SHOW: begin
          display <= blank ? '0 : mem[idx];
          disp_valid <= ~blank;
          cnt <= blank ? '0 : cnt + CW'(1);
          if (blank) begin
            idx <= last ? '0 : idx + LW'(1);
            state <= last ? WAIT : SHOW;
`ifdef ENTRY_TIMEOUT_EN
            tcnt <= '0;
`endif
          end
        end
        WAIT: begin
          if (accept) begin
`ifdef ENTRY_TIMEOUT_EN
            tcnt <= '0;
`endif
            if (x != exp_val) begin
              state <= LOSE;
              result <= 2'd1;
              busy <= 1'b0;
            end else if (!last) idx <= idx + LW'(1);
            else if (level == LW'(DEPTH)) begin
              state <= WIN;
              result <= 2'd2;
              busy <= 1'b0;
            end else begin
              state <= GEN;
              result <= 2'd3;
            end
          end
`ifdef ENTRY_TIMEOUT_EN
          else if (tcnt == TW'(TIMEOUT_CYCLES-1)) begin
            state <= LOSE;
            result <= 2'd1;
            busy <= 1'b0;
          end else tcnt <= tcnt + TW'(1);
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
